// File: rtl/pal_cfg_loader.sv
// Serial loader for the PAL AND/OR planes: shift into a shadow, reject terms selecting both polarities of an input, commit atomically.
// Latency: CFG_LEN accepted bits, then NUM_TERMS check cycles and one commit cycle; done and new planes appear the cycle after commit.
// Backpressure: cfg_ready is high only while shifting; each cycle without cfg_valid there stretches the load by one cycle.
module pal_cfg_loader #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_TERMS   = 4,
    parameter int NUM_OUTPUTS = 2,
    localparam int LIT_W      = 2 * NUM_INPUTS,
    localparam int AND_LEN    = NUM_TERMS * LIT_W,
    localparam int OR_LEN     = NUM_OUTPUTS * NUM_TERMS,
    localparam int CFG_LEN    = AND_LEN + OR_LEN,
    localparam int TERM_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic               cfg_bit,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [TERM_W-1:0]  err_term,
    output logic               cfg_active,
    output logic [AND_LEN-1:0] and_plane_cfg,
    output logic [OR_LEN-1:0]  or_plane_cfg
);

    localparam int CNT_W = $clog2(CFG_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CFG_LEN - 1);
    localparam logic [TERM_W-1:0] TERM_LAST = TERM_W'(NUM_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CFG_LEN-1:0] shadow;
    logic [CNT_W-1:0]   bit_cnt;
    logic [TERM_W-1:0]  term_idx;
    logic [LIT_W-1:0]   term_bits;
    logic               conflict;
    logic               load_clr;
    logic               shift_en;
    logic               check_fail;
    logic               commit;

    // Pick the AND-plane term under inspection and flag any input whose true and inverted literals are both selected.
    always_comb begin
        term_bits = LIT_W'(shadow[CFG_LEN-1:OR_LEN] >> (int'(term_idx) * LIT_W));
        conflict  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            conflict = conflict | (term_bits[2*i] & term_bits[2*i+1]);
        end
    end

    // Next-state and control strobes; a start request outranks an offered bit while shifting.
    always_comb begin
        state_nxt  = state;
        load_clr   = 1'b0;
        shift_en   = 1'b0;
        check_fail = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    load_clr  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cfg_start) begin
                    load_clr = 1'b1;
                end else if (cfg_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_LAST) begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (conflict) begin
                    check_fail = 1'b1;
                    state_nxt  = IDLE;
                end else if (term_idx == TERM_LAST) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake and busy flags are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cfg_ready <= (state_nxt == SHIFT);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Shadow shift register and accepted-bit counter; the first bit received ends up in the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow  <= '0;
            bit_cnt <= '0;
        end else if (load_clr) begin
            shadow  <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shadow  <= {shadow[CFG_LEN-2:0], cfg_bit};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Term index walks one term per check cycle and rests at zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            term_idx <= '0;
        end else if (state == CHECK) begin
            term_idx <= term_idx + 1'b1;
        end else begin
            term_idx <= '0;
        end
    end

    // Sticky rejection status, cleared when a new load begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_term <= '0;
        end else if (load_clr) begin
            err      <= 1'b0;
            err_term <= '0;
        end else if (check_fail) begin
            err      <= 1'b1;
            err_term <= term_idx;
        end
    end

    // Active planes change only on a clean commit, all bits at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done          <= 1'b0;
            cfg_active    <= 1'b0;
            and_plane_cfg <= '0;
            or_plane_cfg  <= '0;
        end else begin
            done <= commit;
            if (commit) begin
                cfg_active    <= 1'b1;
                and_plane_cfg <= shadow[CFG_LEN-1:OR_LEN];
                or_plane_cfg  <= shadow[OR_LEN-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader: directed loads, expected commit/reject events queued at issue time.
// Latency: events are expected at fixed cycle offsets from the start request.
// Backpressure: the driver only advances a bit when valid and ready coincide.
module tb_pal_cfg_loader;

    localparam int CFG_LEN = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_bit;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_term;
    logic        cfg_active;
    logic [31:0] and_plane_cfg;
    logic [7:0]  or_plane_cfg;

    pal_cfg_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_bit       (cfg_bit),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_term      (err_term),
        .cfg_active    (cfg_active),
        .and_plane_cfg (and_plane_cfg),
        .or_plane_cfg  (or_plane_cfg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int          at;
        logic [31:0] andp;
        logic [7:0]  orp;
        logic [1:0]  et;
        bit          act;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   t0 = 0;
    logic err_prev = 1'b0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic void expect_evt(bit is_err, int at, logic [31:0] a, logic [7:0] o,
                                       logic [1:0] et, bit act);
        exp_t e;
        e.is_err = is_err;
        e.at     = at;
        e.andp   = a;
        e.orp    = o;
        e.et     = et;
        e.act    = act;
        exp_q.push_back(e);
    endfunction

    // Monitor: every done pulse or err rising edge must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (done === 1'b1 || (err === 1'b1 && !err_prev))) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {62'd0, done, err}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", {62'd0, done, err}, e.is_err ? 64'd1 : 64'd2);
                chk("event_cycle", cyc, e.at);
                chk("and_plane", and_plane_cfg, e.andp);
                chk("or_plane", or_plane_cfg, e.orp);
                chk("cfg_active", cfg_active, e.act);
                if (e.is_err) chk("err_term", err_term, e.et);
            end
        end
        err_prev = (err === 1'b1);
    end

    task automatic start_load();
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    // Offer bits MSB first until nbits have been accepted; alt offers only on even cycles after t0.
    task automatic shift_word(input logic [CFG_LEN-1:0] w, input bit alt, input int nbits,
                              output int first_x, output int last_x);
        int  idx;
        int  stop;
        int  guard;
        int  n;
        bit  xfer;
        idx = CFG_LEN - 1;
        stop = CFG_LEN - nbits;
        guard = 0;
        n = 0;
        first_x = -1;
        last_x = -1;
        while (idx >= stop && guard < 400) begin
            cfg_valid = alt ? (((cyc - t0) % 2) == 0) : 1'b1;
            cfg_bit = w[idx];
            xfer = (cfg_valid === 1'b1) && (cfg_ready === 1'b1);
            if (xfer) begin
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            @(posedge clk); #1;
            if (xfer) begin
                idx--;
                n++;
            end
            guard++;
        end
        cfg_valid = 1'b0;
        chk("xfer_count", n, nbits);
    endtask

    initial begin
        int fx;
        int lx;
        rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_bit = 1'b0;
        cfg_valid = 1'b0;

        // Reset state, and valid in IDLE is not accepted.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_and", and_plane_cfg, 0);
        chk("rst_or", or_plane_cfg, 0);
        chk("rst_flags", {cfg_ready, busy, done, err, cfg_active}, 0);
        chk("rst_err_term", err_term, 0);
        cfg_valid = 1'b1;
        cfg_bit = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_ready_busy", {cfg_ready, busy}, 0);
        cfg_valid = 1'b0;

        // Clean load.
        start_load();
        expect_evt(1'b0, t0 + 46, 32'h40100401, 8'hA5, 2'd0, 1'b1);
        shift_word(40'h40100401A5, 1'b0, 40, fx, lx);
        chk("first_xfer", fx, t0 + 1);
        chk("last_xfer", lx, t0 + 40);
        chk("check_ready_busy", {cfg_ready, busy}, 2'b01);
        repeat (8) @(posedge clk);
        #1;
        chk("post_commit", {done, busy, cfg_active}, 3'b001);

        // Conflict in term 2: rejected, active planes untouched.
        start_load();
        expect_evt(1'b1, t0 + 44, 32'h40100401, 8'hA5, 2'd2, 1'b1);
        shift_word(40'h400C04015A, 1'b0, 40, fx, lx);
        repeat (8) @(posedge clk);
        #1;
        chk("err_sticky", {err, busy}, 2'b10);

        // New load clears err on start.
        start_load();
        chk("err_cleared", {err, err_term}, 0);
        expect_evt(1'b0, t0 + 46, 32'h80200802, 8'h3C, 2'd0, 1'b1);
        shift_word(40'h802008023C, 1'b0, 40, fx, lx);
        repeat (8) @(posedge clk);

        // Valid only every other cycle.
        start_load();
        expect_evt(1'b0, t0 + 86, 32'h40100401, 8'hA5, 2'd0, 1'b1);
        shift_word(40'h40100401A5, 1'b1, 40, fx, lx);
        chk("alt_first_xfer", fx, t0 + 2);
        chk("alt_last_xfer", lx, t0 + 80);
        repeat (8) @(posedge clk);

        // Restart after 17 bits: that partial stream and the bit offered with start are dropped.
        start_load();
        shift_word(40'h0102040810, 1'b0, 17, fx, lx);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit = 1'b1;
        t0 = cyc;
        expect_evt(1'b0, t0 + 46, 32'h10400104, 8'h96, 2'd0, 1'b1);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        shift_word(40'h1040010496, 1'b0, 40, fx, lx);
        chk("restart_last_xfer", lx, t0 + 40);
        repeat (8) @(posedge clk);

        // Reset during CHECK: everything clears, no done.
        start_load();
        shift_word(40'h802008023C, 1'b0, 40, fx, lx);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_and", and_plane_cfg, 0);
        chk("midrst_or", or_plane_cfg, 0);
        chk("midrst_flags", {cfg_ready, busy, done, err, cfg_active}, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_stays_inactive", {cfg_active, busy, done}, 0);

        chk("events_outstanding", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
